int_halt_ctrl: RTL and testbench
================================

# int_halt_ctrl

Memory-mapped control front end for the interrupt controller and the CPU low-power logic. It decodes I/O bus accesses to IE, IF, IME, POSTFLG and HALTCNT. It drives the interrupt controller's `reg_IE`, `reg_ACK` and `ime` inputs. It also runs the HALT/STOP state machine that pauses the CPU until an enabled interrupt wakes it. It sits between the I/O register bus and `interrupt_controller`, alongside the CPU pause logic.

## Interface
- `WAKE_STOP_MASK`, default 14'h3080: IF/IE bits that can end STOP (serial, keypad, game pak).
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `io_addr`  in  10  word-aligned byte offset within 0x0400_0000 I/O space; bits [1:0] are ignored.
- `io_wdata`  in  32  write data.
- `io_be`  in  4  byte-lane enables.
- `io_we`  in  1  write strobe, one cycle per access.
- `io_re`  in  1  read strobe, one cycle per access.
- `io_rdata`  out  32  read data, valid the cycle after `io_re`.
- `reg_IF`  in  16  enabled, pending flags from `interrupt_controller`.
- `reg_IE`  out  14  interrupt enable register.
- `reg_ACK`  out  14  one-cycle acknowledge pulses to `interrupt_controller`.
- `ime`  out  1  interrupt master enable.
- `cpu_pause`  out  1  stalls the CPU.
- `video_stop`  out  1  gates the video and sound clock enables while in STOP.
- `postflg`  out  1  POSTFLG bit 0.

## Operation
- Address map:
  - 0x200: lanes 0-1 are IE, lanes 2-3 are IF.
  - 0x208: lane 0 bit 0 is IME.
  - 0x300: lane 0 bit 0 is POSTFLG; lane 1 is HALTCNT, write-only.
  - Any other offset reads 0 and ignores writes.
- IE:
  - Byte-lane writable.
  - Bits 15:14 are discarded and read as 0.
- IF:
  - Write-1-to-clear.
  - Bits written 1 on enabled lanes, bits 13:0 only, appear on `reg_ACK` for exactly one cycle, the cycle after `io_we`.
  - `reg_ACK` is 0 in every other cycle.
  - Reading IF returns `{2'b0, reg_IF[13:0]}`.
- IME: bit 0 is stored; the other bits are ignored and read as 0.
- HALTCNT write to lane 1:
  - In RUN, bit 7 = 0 enters HALT and bit 7 = 1 enters STOP.
  - In any other state the write is ignored.
- States are RUN, HALT, STOP and WAKE.
- RUN: `cpu_pause` = 0.
- HALT:
  - `cpu_pause` = 1.
  - Goes to WAKE when `|(reg_IE & reg_IF[13:0])`. IME is ignored.
- STOP:
  - `cpu_pause` = 1 and `video_stop` = 1.
  - Goes to WAKE when `|(reg_IE & reg_IF[13:0] & WAKE_STOP_MASK)`.
- WAKE:
  - `cpu_pause` = 1 for exactly one cycle, then RUN.
  - This cycle covers the registered `nIRQ` latency, so the IRQ is already asserted when the CPU resumes.
- Register writes are accepted in every state, for example DMA writing IE while the CPU is halted.
- If the wake condition is already true in the cycle HALT is entered, the block stays in HALT for one cycle and then goes to WAKE. It never skips HALT.
- If a write and a read hit the same register in the same cycle, `io_rdata` returns the pre-write value.

## Timing
- Reset values:
  - `reg_IE` = 0, `reg_ACK` = 0, `ime` = 0, `postflg` = 0.
  - `io_rdata` = 0, `cpu_pause` = 0, `video_stop` = 0.
  - State = RUN.
- Reset asserted in HALT or STOP returns to RUN immediately and asynchronously; `cpu_pause` drops with it.
- Write latency: IE, IME and POSTFLG update on the clock edge that samples `io_we`, and are visible the next cycle.
- ACK: pulses in cycle N+1 for a write in cycle N. `reg_IF` clears in N+2, because `int_reg` registers the clear.
- HALTCNT write in cycle N: the state changes at the end of N and `cpu_pause` is 1 from N+1.
- Wake condition true in cycle M while in HALT or STOP:
  - WAKE in M+1.
  - RUN in M+2, with `cpu_pause` = 0 from M+2.
- `io_rdata` is registered and holds its value until the next `io_re`.

## Structure
- Shared header `gba_core_defines.vh` holds:
  - the I/O offsets `IO_IE_IF`, `IO_IME`, `IO_HALTCNT`;
  - the `halt_state_t` enum;
  - the IRQ bit indices (VBLANK = 0 … GAMEPAK = 13).
- Sub-module `halt_fsm` holds the state register and the wake logic. Inputs are `halt_req`, `stop_req`, `reg_IE`, `reg_IF` and the mask; outputs are `cpu_pause` and `video_stop`.
- Register decode and ACK generation live in the top module.

## Test plan
- Write IE = 0x0001 (be = 0011) at 0x200, then read 0x200 while `reg_IF` = 0x0001 → `io_rdata` = 0x0001_0001 one cycle after `io_re`.
- Write 0x0005_0000 (be = 1100) at 0x200 → `reg_ACK` = 0x0005 for exactly one cycle, the cycle after the write, then 0. Also write 0xC000_0000 at 0x200 → `reg_ACK` stays 0.
- With IE = 0x0001 and `ime` = 0, write 0x00 to HALTCNT → `cpu_pause` = 1 next cycle. Raise `reg_IF[0]` in cycle M → `cpu_pause` = 1 through M+1 and 0 at M+2.
- STOP (write 0x80) with IE = 0x1001: raise `reg_IF[0]` → no wake and `video_stop` stays 1. Then raise `reg_IF[12]` → WAKE, then RUN.
- Assert `reset` mid-HALT → `cpu_pause`, `reg_IE` and `ime` go to 0 immediately and the state is RUN.
- In HALT, write IME = 1 and IE = 0x0008 via the bus → both update. `reg_IF[3]` then wakes the block.

Source files
------------

// File: rtl/int_halt_ctrl_pkg.sv
// Shared definitions for the interrupt / halt control front end.
// Holds the I/O register offsets, the HALT/STOP state encoding and the
// IRQ bit indices used by int_halt_ctrl and halt_fsm.
package int_halt_ctrl_pkg;

  // Byte offsets within the 0x0400_0000 I/O space (word aligned).
  localparam logic [9:0] IO_IE_IF   = 10'h200;
  localparam logic [9:0] IO_IME     = 10'h208;
  localparam logic [9:0] IO_HALTCNT = 10'h300;

  // CPU low-power state.
  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StHalt = 2'd1,
    StStop = 2'd2,
    StWake = 2'd3
  } halt_state_t;

  // IRQ bit positions in IE / IF.
  localparam int unsigned IRQ_VBLANK  = 0;
  localparam int unsigned IRQ_HBLANK  = 1;
  localparam int unsigned IRQ_VCOUNT  = 2;
  localparam int unsigned IRQ_TIMER0  = 3;
  localparam int unsigned IRQ_TIMER1  = 4;
  localparam int unsigned IRQ_TIMER2  = 5;
  localparam int unsigned IRQ_TIMER3  = 6;
  localparam int unsigned IRQ_SERIAL  = 7;
  localparam int unsigned IRQ_DMA0    = 8;
  localparam int unsigned IRQ_DMA1    = 9;
  localparam int unsigned IRQ_DMA2    = 10;
  localparam int unsigned IRQ_DMA3    = 11;
  localparam int unsigned IRQ_KEYPAD  = 12;
  localparam int unsigned IRQ_GAMEPAK = 13;

  localparam int unsigned IrqW = 14;

endpackage

// File: rtl/halt_fsm.sv
// HALT/STOP state machine. Pauses the CPU from the cycle after a HALT or
// STOP request until an enabled, pending interrupt wakes it; a one-cycle
// WAKE state covers the registered nIRQ latency before RUN resumes.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   halt_req_i         HALTCNT write with bit 7 = 0 (honoured only in RUN)
//   stop_req_i         HALTCNT write with bit 7 = 1 (honoured only in RUN)
//   reg_ie_i           interrupt enable register
//   reg_if_i           pending interrupt flags, bits 13:0
//   wake_mask_i        IRQ bits able to end STOP
//   cpu_pause_o        CPU stall, low only in RUN
//   video_stop_o       video/sound clock-enable gate, high only in STOP
module halt_fsm
  import int_halt_ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            halt_req_i,
  input  logic            stop_req_i,
  input  logic [IrqW-1:0] reg_ie_i,
  input  logic [IrqW-1:0] reg_if_i,
  input  logic [IrqW-1:0] wake_mask_i,
  output logic            cpu_pause_o,
  output logic            video_stop_o
);

  halt_state_t state_q, state_d;
  logic        wake_halt, wake_stop;

  // HALT wakes on any enabled pending IRQ regardless of IME.
  assign wake_halt = |(reg_ie_i & reg_if_i);
  assign wake_stop = |(reg_ie_i & reg_if_i & wake_mask_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cpu_pause_o  = 1'b1;
    video_stop_o = 1'b0;
    unique case (state_q)
      StRun: begin
        cpu_pause_o = 1'b0;
        if (stop_req_i) begin
          state_d = StStop;
        end else if (halt_req_i) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        if (wake_halt) state_d = StWake;
      end
      StStop: begin
        video_stop_o = 1'b1;
        if (wake_stop) state_d = StWake;
      end
      StWake: begin
        state_d = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

endmodule

// File: rtl/int_halt_ctrl.sv
// Memory-mapped control front end for the interrupt controller and CPU
// low-power logic. Decodes I/O accesses to IE/IF (0x200), IME (0x208) and
// POSTFLG/HALTCNT (0x300), generates one-cycle IF acknowledge pulses and
// hosts the HALT/STOP state machine.
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   io_addr        byte offset in I/O space, bits 1:0 ignored
//   io_wdata/io_be write data and byte-lane enables
//   io_we/io_re    one-cycle write / read strobes
//   io_rdata       registered read data, held until the next io_re
//   reg_IF         pending flags from interrupt_controller
//   reg_IE         interrupt enables
//   reg_ACK        one-cycle write-1-to-clear pulses for IF
//   ime            interrupt master enable
//   cpu_pause      CPU stall
//   video_stop     video/sound gate during STOP
//   postflg        POSTFLG bit 0
module int_halt_ctrl
  import int_halt_ctrl_pkg::*;
#(
  parameter logic [13:0] WAKE_STOP_MASK = 14'h3080
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  io_addr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_be,
  input  logic        io_we,
  input  logic        io_re,
  output logic [31:0] io_rdata,
  input  logic [15:0] reg_IF,
  output logic [13:0] reg_IE,
  output logic [13:0] reg_ACK,
  output logic        ime,
  output logic        cpu_pause,
  output logic        video_stop,
  output logic        postflg
);

  logic        hit_ie_if, hit_ime, hit_haltcnt;
  logic [13:0] ie_q, ie_d;
  logic [13:0] ack_q, ack_d;
  logic        ime_q, ime_d;
  logic        postflg_q, postflg_d;
  logic [31:0] rdata_q, rdata_d;
  logic        halt_req, stop_req;
  logic        unused_bits;

  assign hit_ie_if   = (io_addr[9:2] == IO_IE_IF[9:2]);
  assign hit_ime     = (io_addr[9:2] == IO_IME[9:2]);
  assign hit_haltcnt = (io_addr[9:2] == IO_HALTCNT[9:2]);

  // Address LSBs, IF bits 15:14 and some data bits have no home.
  assign unused_bits = ^{io_addr[1:0], reg_IF[15:14], io_wdata[31:30], io_wdata[14]};

  always_comb begin
    ie_d      = ie_q;
    ime_d     = ime_q;
    postflg_d = postflg_q;
    ack_d     = '0;
    if (io_we && hit_ie_if) begin
      if (io_be[0]) ie_d[7:0]  = io_wdata[7:0];
      if (io_be[1]) ie_d[13:8] = io_wdata[13:8];
      // IF lives in the upper half-word; write-1-to-clear becomes an ACK pulse.
      if (io_be[2]) ack_d[7:0]  = io_wdata[23:16];
      if (io_be[3]) ack_d[13:8] = io_wdata[29:24];
    end
    if (io_we && hit_ime && io_be[0]) begin
      ime_d = io_wdata[0];
    end
    if (io_we && hit_haltcnt && io_be[0]) begin
      postflg_d = io_wdata[0];
    end
  end

  assign halt_req = io_we && hit_haltcnt && io_be[1] && !io_wdata[15];
  assign stop_req = io_we && hit_haltcnt && io_be[1] && io_wdata[15];

  // Read mux uses current register values, so a same-cycle write is not seen.
  always_comb begin
    rdata_d = rdata_q;
    if (io_re) begin
      rdata_d = '0;
      if (hit_ie_if) begin
        rdata_d = {2'b00, reg_IF[13:0], 2'b00, ie_q};
      end else if (hit_ime) begin
        rdata_d = {31'd0, ime_q};
      end else if (hit_haltcnt) begin
        rdata_d = {31'd0, postflg_q};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ie_q      <= '0;
      ack_q     <= '0;
      ime_q     <= 1'b0;
      postflg_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ie_q      <= ie_d;
      ack_q     <= ack_d;
      ime_q     <= ime_d;
      postflg_q <= postflg_d;
      rdata_q   <= rdata_d;
    end
  end

  assign reg_IE   = ie_q;
  assign reg_ACK  = ack_q;
  assign ime      = ime_q;
  assign postflg  = postflg_q;
  assign io_rdata = rdata_q;

  halt_fsm u_halt_fsm (
    .clk_i        (clock),
    .rst_i        (reset),
    .halt_req_i   (halt_req),
    .stop_req_i   (stop_req),
    .reg_ie_i     (ie_q),
    .reg_if_i     (reg_IF[13:0]),
    .wake_mask_i  (WAKE_STOP_MASK),
    .cpu_pause_o  (cpu_pause),
    .video_stop_o (video_stop)
  );

endmodule

// File: tb/tb_int_halt_ctrl.sv
// Directed bench for int_halt_ctrl: bus decode, IF acknowledge pulses,
// HALT/STOP entry and wake timing, asynchronous reset.
module tb_int_halt_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_be;
  logic        io_we;
  logic        io_re;
  logic [31:0] io_rdata;
  logic [15:0] reg_IF;
  logic [13:0] reg_IE;
  logic [13:0] reg_ACK;
  logic        ime;
  logic        cpu_pause;
  logic        video_stop;
  logic        postflg;

  int passed = 0;
  int total  = 0;

  int_halt_ctrl #(.WAKE_STOP_MASK(14'h3080)) dut (
    .clock      (clock),
    .reset      (reset),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_be      (io_be),
    .io_we      (io_we),
    .io_re      (io_re),
    .io_rdata   (io_rdata),
    .reg_IF     (reg_IF),
    .reg_IE     (reg_IE),
    .reg_ACK    (reg_ACK),
    .ime        (ime),
    .cpu_pause  (cpu_pause),
    .video_stop (video_stop),
    .postflg    (postflg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    io_addr  = a;
    io_wdata = d;
    io_be    = be;
    io_we    = 1'b1;
    step();
    io_we    = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a);
    io_addr = a;
    io_re   = 1'b1;
    step();
    io_re   = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    io_addr  = '0;
    io_wdata = '0;
    io_be    = '0;
    io_we    = 1'b0;
    io_re    = 1'b0;
    reg_IF   = '0;
    step();
    step();
    chk("rst_ie",      {18'd0, reg_IE}, 32'h0);
    chk("rst_ack",     {18'd0, reg_ACK}, 32'h0);
    chk("rst_ime",     {31'd0, ime}, 32'h0);
    chk("rst_postflg", {31'd0, postflg}, 32'h0);
    chk("rst_rdata",   io_rdata, 32'h0);
    chk("rst_pause",   {31'd0, cpu_pause}, 32'h0);
    chk("rst_vstop",   {31'd0, video_stop}, 32'h0);
    reset = 1'b0;
    step();

    // IE write and IE/IF readback
    wr(10'h200, 32'h0000_0001, 4'b0011);
    chk("ie_wr", {18'd0, reg_IE}, 32'h1);
    chk("ie_wr_noack", {18'd0, reg_ACK}, 32'h0);
    reg_IF = 16'h0001;
    rd(10'h200);
    chk("rd_ie_if", io_rdata, 32'h0001_0001);

    // IF write-1-to-clear pulse
    reg_IF = 16'h0000;
    wr(10'h200, 32'h0005_0000, 4'b1100);
    chk("ack_pulse", {18'd0, reg_ACK}, 32'h5);
    step();
    chk("ack_drop", {18'd0, reg_ACK}, 32'h0);
    wr(10'h200, 32'hC000_0000, 4'b1100);
    chk("ack_hi_bits", {18'd0, reg_ACK}, 32'h0);
    chk("ie_untouched", {18'd0, reg_IE}, 32'h1);
    wr(10'h200, 32'hFFFF_FFFF, 4'b1000);
    chk("ack_lane3", {18'd0, reg_ACK}, 32'h3F00);

    // IE bits 15:14 dropped; IF readback masks 15:14
    wr(10'h200, 32'h0000_FFFF, 4'b0011);
    chk("ie_14bit", {18'd0, reg_IE}, 32'h3FFF);
    reg_IF = 16'hC001;
    rd(10'h200);
    chk("rd_mask", io_rdata, 32'h0001_3FFF);
    reg_IF = 16'h0000;

    // Unmapped offset, IME, POSTFLG
    wr(10'h204, 32'hFFFF_FFFF, 4'b1111);
    rd(10'h204);
    chk("rd_unmapped", io_rdata, 32'h0);
    wr(10'h208, 32'hFFFF_FFFF, 4'b1111);
    chk("ime_set", {31'd0, ime}, 32'h1);
    rd(10'h208);
    chk("rd_ime", io_rdata, 32'h1);
    wr(10'h208, 32'h0, 4'b0001);
    chk("ime_clr", {31'd0, ime}, 32'h0);
    wr(10'h300, 32'h0000_0001, 4'b0001);
    chk("postflg", {31'd0, postflg}, 32'h1);
    chk("postflg_nohalt", {31'd0, cpu_pause}, 32'h0);
    rd(10'h302);
    chk("rd_postflg", io_rdata, 32'h1);
    step();
    step();
    chk("rdata_hold", io_rdata, 32'h1);

    // HALT with IE = 1, IME = 0
    wr(10'h200, 32'h0000_0001, 4'b0011);
    wr(10'h300, 32'h0000_0000, 4'b0010);
    chk("halt_pause", {31'd0, cpu_pause}, 32'h1);
    chk("halt_novstop", {31'd0, video_stop}, 32'h0);
    step();
    chk("halt_hold", {31'd0, cpu_pause}, 32'h1);
    reg_IF = 16'h0001;  // cycle M
    step();             // M+1: WAKE
    chk("halt_wake", {31'd0, cpu_pause}, 32'h1);
    step();             // M+2: RUN
    chk("halt_run", {31'd0, cpu_pause}, 32'h0);
    reg_IF = 16'h0000;

    // STOP with IE = 0x1001
    wr(10'h200, 32'h0000_1001, 4'b0011);
    wr(10'h300, 32'h0000_8000, 4'b0010);
    chk("stop_pause", {31'd0, cpu_pause}, 32'h1);
    chk("stop_vstop", {31'd0, video_stop}, 32'h1);
    reg_IF = 16'h0001;
    step();
    step();
    chk("stop_nowake_p", {31'd0, cpu_pause}, 32'h1);
    chk("stop_nowake_v", {31'd0, video_stop}, 32'h1);
    wr(10'h300, 32'h0000_0000, 4'b0010);  // ignored outside RUN
    step();
    chk("stop_ignore_halt", {31'd0, video_stop}, 32'h1);
    reg_IF = 16'h1001;  // keypad: cycle M
    step();
    chk("stop_wake_p", {31'd0, cpu_pause}, 32'h1);
    chk("stop_wake_v", {31'd0, video_stop}, 32'h0);
    step();
    chk("stop_run", {31'd0, cpu_pause}, 32'h0);
    reg_IF = 16'h0000;

    // Asynchronous reset mid-HALT
    wr(10'h208, 32'h0000_0001, 4'b0001);
    wr(10'h300, 32'h0000_0000, 4'b0010);
    chk("pre_rst_pause", {31'd0, cpu_pause}, 32'h1);
    reset = 1'b1;
    #1;
    chk("arst_pause", {31'd0, cpu_pause}, 32'h0);
    chk("arst_ie", {18'd0, reg_IE}, 32'h0);
    chk("arst_ime", {31'd0, ime}, 32'h0);
    step();
    reset = 1'b0;
    step();
    chk("arst_run", {31'd0, cpu_pause}, 32'h0);

    // Register writes accepted while halted
    wr(10'h300, 32'h0000_0000, 4'b0010);
    wr(10'h208, 32'h0000_0001, 4'b0001);
    chk("halt_ime_wr", {31'd0, ime}, 32'h1);
    wr(10'h200, 32'h0000_0008, 4'b0011);
    chk("halt_ie_wr", {18'd0, reg_IE}, 32'h8);
    chk("halt_still", {31'd0, cpu_pause}, 32'h1);
    reg_IF = 16'h0008;  // cycle M
    step();
    chk("halt2_wake", {31'd0, cpu_pause}, 32'h1);
    step();
    chk("halt2_run", {31'd0, cpu_pause}, 32'h0);

    // Wake already true on HALT entry: HALT, WAKE, then RUN
    wr(10'h300, 32'h0000_0000, 4'b0010);
    chk("imm_halt", {31'd0, cpu_pause}, 32'h1);
    step();
    chk("imm_wake", {31'd0, cpu_pause}, 32'h1);
    step();
    chk("imm_run", {31'd0, cpu_pause}, 32'h0);
    reg_IF = 16'h0000;

    // Same-cycle write and read return the pre-write value
    io_re = 1'b1;
    wr(10'h200, 32'h0000_0002, 4'b0011);
    io_re = 1'b0;
    chk("rw_old", io_rdata, 32'h0000_0008);
    chk("rw_new_ie", {18'd0, reg_IE}, 32'h2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
